ha_serial_adder_ctrl: RTL
=========================

HA_SERIAL_ADDER_CTRL -- requirements
Module: ha_serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 SHALL have port sub  input  1  subtract select; present only with SUB_EN (see Configuration).
REQ-008 SHALL have port busy  output  1  high in LOAD-accepted RUN and DONE states.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking valid result.
REQ-010 SHALL have port sum  output  WIDTH  result bits.
REQ-011 SHALL have port cout  output  1  carry out of the MSB.

Function
REQ-012 SHALL time-share one 1-bit adder cell across all bit positions, built from two half-adder stages (XOR for sum, AND for carry) with the two carries ORed.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; no other reachable states.
REQ-014 IDLE: on an edge with start=1, SHALL load A/B shift registers, clear the carry register, clear the bit counter and go to RUN; otherwise stay in IDLE.
REQ-015 RUN: each edge SHALL add the LSBs of the A/B registers plus carry, shift A/B right one place, shift the sum bit into the sum register MSB (shift right), update carry, and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH edges; on the edge processing bit WIDTH-1 the FSM SHALL go to DONE.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-018 Latency: start accepted at edge T0 -> done high in the cycle after edge T0+WIDTH.
REQ-019 sum and cout SHALL hold the final result from DONE until the next accepted start; sum/cout contents during RUN are undefined to observers.
REQ-020 busy SHALL be 0 only in IDLE.
REQ-021 start while in RUN or DONE SHALL be ignored, with no queuing; a, b and sub SHALL have no effect outside the accepting edge.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH with cout = bit WIDTH of the true sum.
REQ-023 Counter width SHALL be $clog2(WIDTH)+1 bits and SHALL not wrap during RUN.

Reset
REQ-024 rst=1 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the carry, counter and A/B registers.
REQ-025 Reset asserted mid-RUN SHALL abandon the operation; no done pulse SHALL follow.
REQ-026 The first edge after rst deasserts SHALL accept a start if start=1.

Configuration
REQ-027 Macro SERIAL_ADDER_SUB_EN SHALL control subtraction support.
REQ-028 With SERIAL_ADDER_SUB_EN defined, port sub SHALL exist; when sub=1 at accept, B SHALL be loaded inverted and carry preset to 1, so sum = A-B mod 2^WIDTH and cout = 1 when A>=B (no borrow).
REQ-029 With SERIAL_ADDER_SUB_EN undefined, port sub SHALL be absent and behaviour SHALL be addition only, identical to the defined build with sub=0.

Verification (WIDTH=8)
REQ-030 Bench SHALL cover this case: a=0x0F, b=0x01, start 1 cycle -> busy high next cycle; done pulse exactly 9 cycles after the start edge; sum=0x10, cout=0.
REQ-031 Bench SHALL cover this case: a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0xA5, b=0x5A -> sum=0xFF, cout=0.
REQ-032 Bench SHALL cover this case: start held high continuously -> one operation per 10 cycles (IDLE accept, 8 RUN, DONE); start pulses during RUN/DONE produce no extra done.
REQ-033 Bench SHALL cover this case: rst pulsed mid-RUN (4 edges after accept), asynchronous to clk -> outputs 0 at once, no done, next start computes correctly.
REQ-034 Bench SHALL cover this case, with SERIAL_ADDER_SUB_EN defined: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; a=0x07, b=0x05 -> sum=0x02, cout=1.
REQ-035 Bench SHALL cover this case: random a/b over 1000 operations -> {cout,sum} equals a+b (or the subtraction result) with no done-pulse width other than 1.

Source files
------------

// File: rtl/ha_serial_adder_ctrl.sv
// Bit-serial adder: one half-adder-pair cell reused LSB-first over WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to add the sub port (A-B via inverted B and carry-in 1).
module ha_serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             ha1_s, ha1_c, ha2_s, ha2_c;
    logic             bit_sum, bit_carry;
    logic             sub_sel;
    logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Full add built from two half adders; the two carries can never both be 1.
    assign ha1_s     = a_reg[0] ^ b_reg[0];
    assign ha1_c     = a_reg[0] & b_reg[0];
    assign ha2_s     = ha1_s ^ carry;
    assign ha2_c     = ha1_s & carry;
    assign bit_sum   = ha2_s;
    assign bit_carry = ha1_c | ha2_c;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= sub_sel ? ~b : b;
                        carry <= sub_sel;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg   <= {1'b0, b_reg[WIDTH-1:1]};
                    sum_reg <= {bit_sum, sum_reg[WIDTH-1:1]};
                    carry   <= bit_carry;
                    cnt     <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // After the final RUN edge the carry register is the MSB carry-out and
    // stays put until the next accepted start reloads it.
    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign sum  = sum_reg;
    assign cout = carry;
endmodule
